// File: rtl/otter_intr_ctrl_if.sv
// Interrupt controller bus bundle.
// master : the core side (CSR file, commit stage, interrupt sources); drives
//          requests and CSR values, observes redirects and status.
// slave  : the interrupt controller itself.
// Signals:
//   irq_src     level request lines, synchronous to clk
//   mstatus/mie global / local interrupt enables
//   mtvec/mepc  trap handler / return addresses
//   mret_req    commit-point instruction is mret
//   pipe_ready  instruction boundary available, redirect permitted
//   int_taken / int_ret / redirect / irq_ack   one-cycle event pulses
//   redirect_pc target PC while redirect is high, else 0
//   cause       index of the last serviced source
//   in_handler  handler currently active
//   overrun     sticky per-source overrun flags
interface otter_intr_ctrl_if #(parameter int N_SRC = 4);
  logic [N_SRC-1:0] irq_src;
  logic             mstatus;
  logic             mie;
  logic [31:0]      mtvec;
  logic [31:0]      mepc;
  logic             mret_req;
  logic             pipe_ready;
  logic             int_taken;
  logic             int_ret;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [N_SRC-1:0] irq_ack;
  logic [2:0]       cause;
  logic             in_handler;
  logic [N_SRC-1:0] overrun;

  modport master (
    output irq_src, mstatus, mie, mtvec, mepc, mret_req, pipe_ready,
    input  int_taken, int_ret, redirect, redirect_pc, irq_ack, cause,
           in_handler, overrun
  );

  modport slave (
    input  irq_src, mstatus, mie, mtvec, mepc, mret_req, pipe_ready,
    output int_taken, int_ret, redirect, redirect_pc, irq_ack, cause,
           in_handler, overrun
  );
endinterface

// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt controller.
// Records rising edges on N_SRC level request lines as pending requests,
// takes the lowest-index pending request at an instruction boundary when
// interrupts are enabled, and handles mret returns. A one-cycle COOL state
// after every return gives the CSR mstatus update time to settle before the
// next take can fire.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  otter_intr_ctrl_if.slave (see interface header for signal list)
// Take/return pulses, redirect and redirect_pc are combinational in the
// cycle the event fires; cause, in_handler and overrun are registered.
module otter_intr_ctrl #(
  parameter int N_SRC = 4
) (
  input  logic                clk,
  input  logic                rst,
  otter_intr_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, HANDLER, COOL} state_t;

  state_t           state, state_nxt;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack;
  logic [N_SRC-1:0] overrun;
  logic [2:0]       k;
  logic [2:0]       cause;
  logic             in_handler;
  logic             take, ret;

  assign rise = bus.irq_src & ~irq_q;

  // Lowest-index pending source wins; onehot and index built together.
  logic [N_SRC-1:0] low_oh;
  always_comb begin
    low_oh = '0;
    k      = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        low_oh    = '0;
        low_oh[i] = 1'b1;
        k         = i[2:0];
      end
    end
  end

  // Return outranks take; both are suppressed during reset.
  assign ret  = ~rst & bus.mret_req & bus.pipe_ready;
  assign take = ~rst & (state == IDLE) & (|pend) & bus.mstatus & bus.mie
              & bus.pipe_ready & ~bus.mret_req;
  assign ack  = take ? low_oh : '0;

  always_comb begin
    state_nxt = state;
    if (ret) begin
      state_nxt = COOL;
    end else begin
      case (state)
        IDLE:    state_nxt = take ? HANDLER : IDLE;
        HANDLER: state_nxt = HANDLER;
        COOL:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_handler <= 1'b0;
      irq_q      <= '0;
      pend       <= '0;
      overrun    <= '0;
      cause      <= '0;
    end else begin
      state      <= state_nxt;
      in_handler <= (state_nxt == HANDLER);
      irq_q      <= bus.irq_src;
      // A clear and a new edge in the same cycle leave the source pending
      // without flagging overrun.
      pend       <= (pend & ~ack) | rise;
      overrun    <= overrun | (rise & pend & ~ack);
      if (take) cause <= k;
    end
  end

  assign bus.int_taken   = take;
  assign bus.int_ret     = ret;
  assign bus.redirect    = take | ret;
  assign bus.redirect_pc = ret ? bus.mepc : (take ? bus.mtvec : 32'h0);
  assign bus.irq_ack     = ack;
  assign bus.cause       = cause;
  assign bus.in_handler  = in_handler;
  assign bus.overrun     = overrun;

endmodule

// File: doc/otter_intr_ctrl.md
OTTER_INTR_CTRL -- requirements
Module: otter_intr_ctrl

Interface
REQ-001 Clock and reset SHALL be: clk, rst -- rst is synchronous, active-high; all state updates on posedge clk.
REQ-002 Parameter N_SRC, default 4, SHALL give the number of interrupt sources, range 1..8.
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- irq_src  in  N_SRC  interrupt request lines, already synchronous to clk, level
- mstatus  in  1  global interrupt enable from the CSR file
- mie  in  1  interrupt enable from the CSR file
- mtvec  in  32  trap handler address from the CSR file
- mepc  in  32  return address from the CSR file
- mret_req  in  1  the instruction at the commit point is mret
- pipe_ready  in  1  an instruction boundary is available this cycle; a redirect is permitted
- int_taken  out  1  one-cycle pulse; drives the CSR intTaken input
- int_ret  out  1  one-cycle pulse; drives the CSR intRet input
- redirect  out  1  one-cycle pulse; the PC loads redirect_pc
- redirect_pc  out  32  target PC while redirect is high, else 0
- irq_ack  out  N_SRC  one-hot pulse identifying the serviced source
- cause  out  3  index of the last serviced source; held until the next take
- in_handler  out  1  high from the cycle after a take until the cycle after the matching return
- overrun  out  N_SRC  sticky per source; set when an edge arrives while that source is already pending

Function
REQ-004 Edge detect: irq_q SHALL register irq_src; a rising edge on source i is irq_src[i] & ~irq_q[i].
REQ-005 A rising edge SHALL set pend[i]; if pend[i] is already 1 and not being cleared that cycle, overrun[i] SHALL be set.
REQ-006 pend[i] SHALL clear only in the cycle its take fires; a new edge in that same cycle SHALL re-set pend[i] and SHALL NOT set overrun.
REQ-007 The FSM SHALL have three states: IDLE, HANDLER and COOL.
REQ-008 In IDLE, a take SHALL fire when all of these hold: |pend, mstatus, mie, pipe_ready, and ~mret_req.
REQ-009 Take priority SHALL be the lowest-index pending source.
REQ-010 Take cycle, combinational outputs: int_taken=1, redirect=1, redirect_pc=mtvec, irq_ack[k]=1.
REQ-011 Take cycle, registered updates at the next edge: cause<=k, pend[k]<=0, state<=HANDLER.
REQ-012 In any state, mret_req & pipe_ready SHALL fire a return: int_ret=1, redirect=1, redirect_pc=mepc, state<=COOL.
REQ-013 When a return and a take qualify in the same cycle, the return SHALL win and no take SHALL fire.
REQ-014 In HANDLER, no take SHALL fire regardless of mstatus, mie or pend; edges SHALL still be recorded.
REQ-015 COOL SHALL last exactly one cycle and then go to IDLE with no take; this lets the CSR mstatus update settle.
REQ-016 in_handler SHALL be 1 exactly when state==HANDLER.
REQ-017 int_taken, int_ret, redirect and irq_ack SHALL never be high for more than one consecutive cycle per event.
REQ-018 int_taken and int_ret SHALL never be high in the same cycle.
REQ-019 When pipe_ready=0, no take or return SHALL fire; the pending condition holds until pipe_ready rises.

Reset
REQ-020 On rst, the next state SHALL be: state=IDLE, pend=0, irq_q=0, overrun=0, cause=0.
REQ-021 While rst is asserted, int_taken, int_ret, redirect and irq_ack SHALL be 0 and redirect_pc SHALL be 0.
REQ-022 An rst asserted in any state, including mid-HANDLER, SHALL abandon the handler and discard all pending requests.
REQ-023 Because irq_q resets to 0, a source held high through reset SHALL register one edge in the first cycle after rst deasserts.

Verification
REQ-024 Basic take: mstatus=mie=1, pipe_ready=1, mtvec=0x100, irq_src[2] rises -> next cycle int_taken=1, redirect_pc=0x100, irq_ack=0100; then cause=2 and in_handler=1.
REQ-025 Priority: sources 1 and 3 rise together -> the take acks source 1; after an mret and one COOL cycle, source 3 is taken on the next qualifying cycle.
REQ-026 Return: in HANDLER with mepc=0x2C, mret_req=1, pipe_ready=1 -> int_ret=1, redirect_pc=0x2C; then one COOL cycle, then IDLE.
REQ-027 Simultaneous: IDLE, pend=1 and mret_req=1 in the same cycle -> only int_ret fires; the take fires two cycles later, after COOL.
REQ-028 Stall and overrun: pipe_ready=0 while source 0 pulses twice -> no take and overrun[0]=1; pipe_ready rises -> exactly one take.
REQ-029 Reset mid-handler: rst asserted in HANDLER with pend=0010 -> in_handler=0, pend=0, no take fires after rst deasserts.
